// File: rtl/shift_fill_seq.sv
// shift_fill_seq: multi-cycle shifter with a selectable fill bit. A request
// carries a word, an amount, a direction and a fill bit. The word is shifted
// by at most STEP positions per cycle until the clamped amount is used up.
// The result is then held on rsp_data until it is consumed.
// Optional build macro SHIFT_FILL_SEQ_STATS_EN adds a 16-bit op_count output
// that counts response handshakes.
module shift_fill_seq #(
  parameter int WIDTH = 64,
  parameter int STEP  = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic [WIDTH-1:0]           req_data,
  input  logic [$clog2(WIDTH):0]     req_amt,
  input  logic                       req_fill,
  input  logic                       req_dir,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [WIDTH-1:0]           rsp_data,
  output logic                       busy
`ifdef SHIFT_FILL_SEQ_STATS_EN
  ,
  output logic [15:0]                op_count
`endif
);

  localparam int AW = $clog2(WIDTH) + 1;
  localparam logic [AW-1:0] STEP_A  = AW'(STEP);
  localparam logic [AW-1:0] WIDTH_A = AW'(WIDTH);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] word;
  logic             fill;
  logic             dir;
  logic [AW-1:0]    remaining;

  logic [AW-1:0]    k;
  logic [AW-1:0]    rem_next;
  logic [AW-1:0]    amt_clamped;
  logic [WIDTH-1:0] shifted;

  // Ready and busy are decoded straight from the state register. Forcing
  // ready low through rst_n keeps it at 0 for as long as reset is held.
  assign req_ready = rst_n && (state == IDLE);
  assign busy      = (state != IDLE);

  // One shift step: move by up to STEP positions and set the vacated bits
  // to the captured fill value.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so
    // that no path through it can leave a value unassigned and infer a latch.
    k        = (remaining > STEP_A) ? STEP_A : remaining;
    rem_next = remaining - k;
    shifted  = '0;
    if (dir) begin
      shifted = (word >> k) | (fill ? ~({WIDTH{1'b1}} >> k) : '0);
    end else begin
      shifted = (word << k) | (fill ? ~({WIDTH{1'b1}} << k) : '0);
    end
    amt_clamped = (req_amt > WIDTH_A) ? WIDTH_A : req_amt;
  end

  // Control FSM and datapath registers. In DONE, the first cycle loads the
  // result onto rsp_data. From then on the result is held until it is taken.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: the working word is reset along with the control state. It is a
    // single register, not a memory array, so the reset costs little. It also
    // keeps an aborted operation from leaving stale data behind.
    if (!rst_n) begin
      state     <= IDLE;
      word      <= '0;
      fill      <= 1'b0;
      dir       <= 1'b0;
      remaining <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignments only. Every
      // register then updates from values sampled before the edge.
      unique case (state)
        IDLE: begin
          if (req_valid) begin
            word      <= req_data;
            fill      <= req_fill;
            dir       <= req_dir;
            remaining <= amt_clamped;
            state     <= (amt_clamped == '0) ? DONE : SHIFT;
          end
        end
        SHIFT: begin
          word      <= shifted;
          remaining <= rem_next;
          if (rem_next == '0) state <= DONE;
        end
        DONE: begin
          if (!rsp_valid) begin
            rsp_valid <= 1'b1;
            rsp_data  <= word;
          end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SHIFT_FILL_SEQ_STATS_EN
  // Count completed response handshakes. The counter wraps naturally at
  // 16 bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_count <= '0;
    end else if (rsp_valid && rsp_ready) begin
      op_count <= op_count + 16'd1;
    end
  end
`else
  // Statistics counter not built.
`endif

endmodule

// File: doc/shift_fill_seq.md
SHIFT_FILL_SEQ -- requirements
Module: shift_fill_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 64, data word width in bits (power of two, 8..256).
REQ-002 SHALL have parameter STEP, default 8, maximum bit positions shifted per cycle (power of two, 1..WIDTH).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port req_valid  input  1  request present.
REQ-006 SHALL have port req_ready  output  1  request accepted when req_valid && req_ready.
REQ-007 SHALL have port req_data  input  WIDTH  operand word.
REQ-008 SHALL have port req_amt  input  $clog2(WIDTH)+1  shift amount, 0..2*WIDTH-1.
REQ-009 SHALL have port req_fill  input  1  0 = '0 fill, 1 = '1 fill (all vacated bits).
REQ-010 SHALL have port req_dir  input  1  0 = left shift, 1 = right shift.
REQ-011 SHALL have port rsp_valid  output  1  result present.
REQ-012 SHALL have port rsp_ready  input  1  result consumed when rsp_valid && rsp_ready.
REQ-013 SHALL have port rsp_data  output  WIDTH  shifted result.
REQ-014 SHALL have port busy  output  1  high whenever state != IDLE.

Function
REQ-015 SHALL implement FSM states IDLE, SHIFT, DONE.
REQ-016 req_ready SHALL be 1 only in IDLE; requests are never accepted in SHIFT or DONE.
REQ-017 On acceptance SHALL capture req_data, req_fill, req_dir, and remaining = min(req_amt, WIDTH).
REQ-018 Acceptance with remaining == 0 SHALL go IDLE -> DONE; otherwise IDLE -> SHIFT.
REQ-019 Each SHIFT cycle SHALL shift the held word by k = min(remaining, STEP) in req_dir, filling the k vacated bits with the captured fill bit replicated, and decrement remaining by k.
REQ-020 SHIFT -> DONE SHALL occur on the cycle where remaining reaches 0.
REQ-021 Latency: acceptance at edge N gives rsp_valid high after edge N+1+ceil(min(amt,WIDTH)/STEP).
REQ-022 Amounts >= WIDTH SHALL yield all fill bits (64'h0 or 64'hFFFF_FFFF_FFFF_FFFF at WIDTH=64), never a truncated-shift result.
REQ-023 In DONE, rsp_valid SHALL be 1 and rsp_data stable until rsp_ready; on handshake DONE -> IDLE.
REQ-024 rsp_data SHALL equal 0 whenever rsp_valid is 0.
REQ-025 Inputs req_* SHALL be ignored outside the acceptance cycle.

Reset
REQ-026 rst_n low SHALL force IDLE immediately, asynchronously, regardless of clk.
REQ-027 Reset values: req_ready=1 after release (0 while asserted), rsp_valid=0, rsp_data=0, busy=0, remaining=0.
REQ-028 Reset during SHIFT or DONE SHALL discard the in-flight operation with no response.

Configuration
REQ-029 Macro SHIFT_FILL_SEQ_STATS_EN defined: SHALL add output op_count [15:0], incremented on each response handshake, wrapping 16'hFFFF -> 0, reset to 0.
REQ-030 Macro undefined: op_count port and counter SHALL be absent; all other behaviour identical.

Verification
REQ-031 Left, fill=0, data=64'hFFFF_FFFF_FFFF_FFFF, amt=8, rsp_ready=1 -> rsp_data=64'hFFFF_FFFF_FFFF_FF00, rsp_valid 2 cycles after acceptance.
REQ-032 Left, fill=1, data=0, amt=8 -> rsp_data=64'h0000_0000_0000_00FF; amt=0 -> rsp_data=data, rsp_valid 1 cycle after acceptance.
REQ-033 Right, fill=1, data=0, amt=20 -> rsp_data=64'hFFFF_F000_0000_0000 after 4 cycles (3 SHIFT).
REQ-034 amt=100, fill=1, any data -> rsp_data=all ones after 9 cycles; fill=0 -> all zeros.
REQ-035 Hold rsp_ready=0 for 3 cycles in DONE -> rsp_data stable, req_ready=0, new req_valid ignored; release -> IDLE next cycle; with STATS_EN op_count +1.
REQ-036 Assert rst_n low mid-SHIFT (amt=64) -> outputs at reset values without clock edge; no rsp_valid after release.
